wb_arbiter: RTL and testbench

//  Writer side of the integer/FP register bank write port.

---
 rtl/wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-bank write-port arbiter: merges ALU, load and FPU results into a single
// registered write stream and tracks pending writes per register for hazard stalls.
module wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    localparam int unsigned RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    // single-cycle ALU, never back-pressured
    input  logic            alu_valid,
    input  logic [RW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    // load unit
    input  logic            mem_valid,
    input  logic [RW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    // multi-cycle FPU
    input  logic            fpu_valid,
    input  logic [RW-1:0]   fpu_rd,
    input  logic [XLEN-1:0] fpu_data,
    output logic            fpu_ready,
    // issue-side hazard interface
    input  logic            issue_valid,
    input  logic [RW-1:0]   issue_rs1,
    input  logic [RW-1:0]   issue_rs2,
    input  logic [RW-1:0]   issue_rd,
    output logic            issue_stall,
    output logic [NREG-1:0] busy,
    // register-bank write port
    output logic            wb_signal,
    output logic [RW-1:0]   rd,
    output logic [XLEN-1:0] wb_data
);

    // Which of the two back-pressured producers won the last mem/fpu arbitration
    typedef enum logic {
        SrcMem = 1'b0,
        SrcFpu = 1'b1
    } src_e;

    src_e            rr_last_q;
    logic            wb_signal_q;
    logic [RW-1:0]   rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic            grant_mem;
    logic            grant_fpu;
    logic            grant_any;
    logic [RW-1:0]   grant_rd;
    logic [XLEN-1:0] grant_data;
    logic            issue_set;

    // Grant selection: ALU has absolute priority, mem/fpu share round-robin
    always_comb begin
        grant_mem  = 1'b0;
        grant_fpu  = 1'b0;
        grant_any  = 1'b0;
        grant_rd   = '0;
        grant_data = '0;
        if (alu_valid) begin
            grant_any  = 1'b1;
            grant_rd   = alu_rd;
            grant_data = alu_data;
        end else if (mem_valid && fpu_valid) begin
            // the unit that did not win last time goes first
            if (rr_last_q == SrcFpu) begin
                grant_mem = 1'b1;
            end else begin
                grant_fpu = 1'b1;
            end
        end else if (mem_valid) begin
            grant_mem = 1'b1;
        end else if (fpu_valid) begin
            grant_fpu = 1'b1;
        end
        if (grant_mem) begin
            grant_any  = 1'b1;
            grant_rd   = mem_rd;
            grant_data = mem_data;
        end else if (grant_fpu) begin
            grant_any  = 1'b1;
            grant_rd   = fpu_rd;
            grant_data = fpu_data;
        end
    end

    // Ready is combinational but must never leak an accept while reset is held
    always_comb begin
        mem_ready = grant_mem & ~rst;
        fpu_ready = grant_fpu & ~rst;
    end

    // Hazard check; WAW term ignored for a destination-less instruction
    always_comb begin
        issue_stall = issue_valid &
                      (busy_q[issue_rs1] | busy_q[issue_rs2] |
                       ((issue_rd != '0) & busy_q[issue_rd]));
        issue_set   = issue_valid & ~issue_stall & (issue_rd != '0);
    end

    // Scoreboard next state: clear on bank write, then set so that set wins
    always_comb begin
        busy_d = busy_q;
        if (wb_signal_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Registered write port, round-robin pointer and scoreboard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_signal_q <= 1'b0;
            rd_q        <= '0;
            wb_data_q   <= '0;
            rr_last_q   <= SrcFpu;
            busy_q      <= '0;
        end else begin
            // x0 results are consumed but never written
            wb_signal_q <= grant_any && (grant_rd != '0);
            if (grant_any) begin
                rd_q      <= grant_rd;
                wb_data_q <= grant_data;
            end
            if (grant_mem) begin
                rr_last_q <= SrcMem;
            end else if (grant_fpu) begin
                rr_last_q <= SrcFpu;
            end
            busy_q <= busy_d;
        end
    end

    assign wb_signal = wb_signal_q;
    assign rd        = rd_q;
    assign wb_data   = wb_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed stimulus, a cycle-level reference model checked on
// every falling edge, and literal expectations at the points of interest.
module tb_wb_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = $clog2(NREG);

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, mem_valid, fpu_valid, issue_valid;
    logic [RW-1:0]   alu_rd, mem_rd, fpu_rd, issue_rs1, issue_rs2, issue_rd;
    logic [XLEN-1:0] alu_data, mem_data, fpu_data;
    logic            mem_ready, fpu_ready, issue_stall, wb_signal;
    logic [NREG-1:0] busy;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] wb_data;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .fpu_valid(fpu_valid), .fpu_rd(fpu_rd), .fpu_data(fpu_data), .fpu_ready(fpu_ready),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_stall(issue_stall), .busy(busy),
        .wb_signal(wb_signal), .rd(rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Current state of the bank-write pipeline and scoreboard, and the state it becomes.
    bit            m_busy[NREG];
    int            m_last;      // 0 = mem won last, 1 = fpu won last
    bit            m_wb;
    int            m_rd;
    logic [XLEN-1:0] m_data;
    bit            n_busy[NREG];
    int            n_last;
    bit            n_wb;
    int            n_rd;
    logic [XLEN-1:0] n_data;

    function automatic logic [NREG-1:0] pack_busy();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    always @(negedge clk) begin
        bit exp_mr, exp_fr, exp_st, got;
        int g_rd;
        logic [XLEN-1:0] g_data;
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin m_busy[i] = 0; n_busy[i] = 0; end
            m_last = 1; n_last = 1; m_wb = 0; n_wb = 0;
            m_rd = 0; n_rd = 0; m_data = '0; n_data = '0;
            chk("rst_wb_signal", 64'(wb_signal), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_rd", 64'(rd), 64'd0);
            chk("rst_wb_data", 64'(wb_data), 64'd0);
            chk("rst_mem_ready", 64'(mem_ready), 64'd0);
            chk("rst_fpu_ready", 64'(fpu_ready), 64'd0);
        end else begin
            // who gets the write port this cycle
            exp_mr = 0; exp_fr = 0; got = 0; g_rd = 0; g_data = '0;
            if (alu_valid) begin
                got = 1; g_rd = int'(alu_rd); g_data = alu_data;
            end else if (mem_valid && fpu_valid) begin
                if (m_last == 1) exp_mr = 1; else exp_fr = 1;
            end else begin
                exp_mr = mem_valid;
                exp_fr = fpu_valid;
            end
            if (exp_mr) begin got = 1; g_rd = int'(mem_rd); g_data = mem_data; end
            if (exp_fr) begin got = 1; g_rd = int'(fpu_rd); g_data = fpu_data; end
            exp_st = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] ||
                                     (issue_rd != 0 && m_busy[issue_rd]));

            chk("mem_ready", 64'(mem_ready), 64'(exp_mr));
            chk("fpu_ready", 64'(fpu_ready), 64'(exp_fr));
            chk("issue_stall", 64'(issue_stall), 64'(exp_st));
            chk("busy", 64'(busy), 64'(pack_busy()));
            chk("wb_signal", 64'(wb_signal), 64'(m_wb));
            if (m_wb) begin
                chk("rd", 64'(rd), 64'(m_rd));
                chk("wb_data", 64'(wb_data), 64'(m_data));
            end

            // state after the coming rising edge
            n_wb = got && g_rd != 0;
            n_rd = got ? g_rd : m_rd;
            n_data = got ? g_data : m_data;
            n_last = exp_mr ? 0 : (exp_fr ? 1 : m_last);
            n_busy = m_busy;
            if (m_wb) n_busy[m_rd] = 0;
            if (issue_valid && !exp_st && issue_rd != 0) n_busy[issue_rd] = 1;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = n_busy; m_last = n_last; m_wb = n_wb; m_rd = n_rd; m_data = n_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; mem_valid = 0; fpu_valid = 0; issue_valid = 0;
    endtask

    initial begin
        bit rr_exp_mem[4];
        rr_exp_mem[0] = 1; rr_exp_mem[1] = 0; rr_exp_mem[2] = 1; rr_exp_mem[3] = 0;
        rst = 1;
        idle();
        alu_rd = '0; mem_rd = '0; fpu_rd = '0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
        alu_data = '0; mem_data = '0; fpu_data = '0;
        cyc(); cyc();
        rst = 0;

        // ALU write, one-cycle latency
        cyc(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        @(negedge clk); chk("t2_mem_ready", 64'(mem_ready), 64'd0);
        cyc(); idle();
        @(negedge clk);
        chk("t2_wb", 64'(wb_signal), 64'd1);
        chk("t2_rd", 64'(rd), 64'd5);
        chk("t2_data", 64'(wb_data), 64'hDEADBEEF);
        cyc();
        @(negedge clk); chk("t2_wb_off", 64'(wb_signal), 64'd0);

        // ALU beats load; load goes next, writes back to back
        cyc(); alu_valid = 1; alu_rd = 3; alu_data = 32'h1111;
        mem_valid = 1; mem_rd = 4; mem_data = 32'h2222;
        @(negedge clk); chk("t3_mem_blocked", 64'(mem_ready), 64'd0);
        cyc(); alu_valid = 0;
        @(negedge clk);
        chk("t3_mem_ready", 64'(mem_ready), 64'd1);
        chk("t3_rd_alu", 64'(rd), 64'd3);
        cyc(); mem_valid = 0;
        @(negedge clk);
        chk("t3_wb_mem", 64'(wb_signal), 64'd1);
        chk("t3_rd_mem", 64'(rd), 64'd4);
        chk("t3_data_mem", 64'(wb_data), 64'h2222);

        // reset mid-stream with a pending register and an offered load
        cyc(); issue_valid = 1; issue_rd = 12;
        cyc(); issue_valid = 0; mem_valid = 1; mem_rd = 6; mem_data = 32'h6666;
        @(negedge clk);
        chk("t1_busy12", 64'(busy[12]), 64'd1);
        chk("t1_pre_ready", 64'(mem_ready), 64'd1);
        #2 rst = 1;
        #1;
        chk("t1_wb", 64'(wb_signal), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_mem_ready", 64'(mem_ready), 64'd0);
        cyc(); cyc();
        rst = 0; idle();

        // round robin after reset: mem, fpu, mem, fpu
        cyc(); mem_valid = 1; mem_rd = 10; mem_data = 32'hA0;
        fpu_valid = 1; fpu_rd = 11; fpu_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_mem_grant", 64'(mem_ready), 64'(rr_exp_mem[i]));
            chk("t4_fpu_grant", 64'(fpu_ready), 64'(!rr_exp_mem[i]));
            cyc();
        end
        idle();

        // FPU result to x0: consumed, never written
        cyc(); fpu_valid = 1; fpu_rd = 0; fpu_data = 32'h55;
        @(negedge clk); chk("t5_fpu_ready", 64'(fpu_ready), 64'd1);
        cyc(); idle();
        @(negedge clk);
        chk("t5_wb", 64'(wb_signal), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);

        // scoreboard: set, RAW stall until bank write, then release
        cyc(); issue_valid = 1; issue_rd = 7; issue_rs1 = 0; issue_rs2 = 0;
        @(negedge clk); chk("t6_no_stall", 64'(issue_stall), 64'd0);
        cyc(); issue_rd = 0; issue_rs1 = 7;
        @(negedge clk);
        chk("t6_busy7", 64'(busy[7]), 64'd1);
        chk("t6_stall_a", 64'(issue_stall), 64'd1);
        cyc(); alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        @(negedge clk); chk("t6_stall_b", 64'(issue_stall), 64'd1);
        cyc(); alu_valid = 0;
        @(negedge clk);
        chk("t6_wb7", 64'(wb_signal), 64'd1);
        chk("t6_stall_nobypass", 64'(issue_stall), 64'd1);
        cyc();
        @(negedge clk);
        chk("t6_released", 64'(issue_stall), 64'd0);
        chk("t6_busy7_clr", 64'(busy[7]), 64'd0);
        cyc(); idle(); issue_rs1 = 0;

        // same-edge set and clear of r9: set wins
        cyc(); alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        cyc(); alu_valid = 0; issue_valid = 1; issue_rd = 9;
        @(negedge clk);
        chk("t6_wb9", 64'(wb_signal), 64'd1);
        chk("t6_nostall9", 64'(issue_stall), 64'd0);
        cyc(); idle();
        @(negedge clk); chk("t6_busy9", 64'(busy[9]), 64'd1);
        // WAW on r9 now stalls; rd=0 never stalls on its own
        cyc(); issue_valid = 1; issue_rd = 9;
        @(negedge clk); chk("t6_waw", 64'(issue_stall), 64'd1);
        cyc(); issue_rd = 0;
        @(negedge clk); chk("t6_rd0", 64'(issue_stall), 64'd0);
        cyc(); idle();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
